axis_frame_arbiter: RTL
=======================

AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

Interface
REQ-001 SHALL have parameter S_COUNT, default 4, number of AXI-Stream input ports, 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, tdata width per port.
REQ-003 SHALL have parameter USER_WIDTH, default 1, tuser width per port.
REQ-004 SHALL have parameter ID_WIDTH, default $clog2(S_COUNT), width of the source-index tag.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port s_axis_tdata  input  S_COUNT*DATA_WIDTH  packed input data; port i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port s_axis_tvalid  input  S_COUNT  per-port valid.
REQ-009 SHALL have port s_axis_tready  output  S_COUNT  per-port ready.
REQ-010 SHALL have port s_axis_tlast  input  S_COUNT  per-port end of frame.
REQ-011 SHALL have port s_axis_tuser  input  S_COUNT*USER_WIDTH  packed per-port user sideband.
REQ-012 SHALL have ports m_axis_tdata/tvalid/tlast/tuser as outputs of widths DATA_WIDTH/1/1/USER_WIDTH, and m_axis_tready as a 1-bit input; this is the merged output stream.
REQ-013 SHALL have port m_axis_tid  output  ID_WIDTH  index of the source port of the current beat.
REQ-014 SHALL have port grant_valid  output  1  high while a frame is granted.
REQ-015 SHALL have port grant_index  output  ID_WIDTH  currently granted port; holds the last value while grant_valid is low.

Function
REQ-016 SHALL implement FSM states IDLE and ACTIVE.
REQ-017 SHALL, in IDLE with any s_axis_tvalid high, latch the winner into grant_index, set grant_valid and enter ACTIVE on the next edge; IDLE with no request keeps IDLE.
REQ-018 SHALL drive s_axis_tready[i] high only in ACTIVE, for i == grant_index, and only when the output skid stage has a free slot; all other tready bits SHALL be 0.
REQ-019 SHALL forward the granted tdata/tlast/tuser and m_axis_tid = grant_index through a registered output stage with a one-entry skid register: latency 1 cycle, sustained 1 beat/cycle, no beat lost or duplicated under any m_axis_tready pattern.
REQ-020 SHALL keep m_axis_* stable while m_axis_tvalid is high and m_axis_tready is low.
REQ-021 SHALL, on an accepted beat with s_axis_tlast high, clear grant_valid and return to IDLE on that edge; arbitration SHALL resume the next cycle (exactly one idle cycle between frames).
REQ-022 SHALL never switch the grant mid-frame, regardless of other requests.
REQ-023 SHALL ignore a granted source deasserting tvalid mid-frame (grant held, bubbles pass through).
REQ-024 SHALL treat a single-beat frame (tlast on first beat) as a complete frame.

Reset
REQ-025 SHALL, while rst is high, asynchronously force state=IDLE, grant_valid=0, grant_index=0, all s_axis_tready=0, m_axis_tvalid=0, skid register empty, and round-robin pointer=0.
REQ-026 SHALL discard a partially transferred frame on reset; no tlast is emitted for it.
REQ-027 SHALL leave m_axis_tdata/tlast/tuser/tid values don't-care after reset while m_axis_tvalid=0.

Configuration
REQ-028 SHALL, with macro AXIS_ARB_ROUND_ROBIN_EN defined, select the first requester searching upward from (last grant + 1) modulo S_COUNT.
REQ-029 SHALL, without AXIS_ARB_ROUND_ROBIN_EN, use fixed priority: the lowest requesting index wins; the round-robin pointer SHALL be absent.

Verification
REQ-030 SHALL cover: S_COUNT=4, port 2 sends a 3-beat frame, m_axis_tready=1 -> 3 beats out with tid=2, tlast on the third, first beat one cycle after acceptance.
REQ-031 SHALL cover: ports 0..3 all requesting continuously with 2-beat frames, round-robin build -> grant order 0,1,2,3,0; fixed-priority build -> 0,0,0.
REQ-032 SHALL cover: port 1 mid-frame while port 0 asserts tvalid -> port 0 tready stays 0 until port 1 tlast is accepted.
REQ-033 SHALL cover: m_axis_tready toggling 1,0,0,1 during an 8-beat frame of data 0x00..0x07 -> output 0x00..0x07 in order with no gaps beyond the stalls and no duplicates.
REQ-034 SHALL cover: rst asserted asynchronously after beat 2 of a 5-beat frame -> m_axis_tvalid, grant_valid and all tready drop immediately; after release, arbitration restarts in IDLE with no stale tlast.

Source files
------------

// File: rtl/axis_frame_arbiter.sv
// Frame-level AXI-Stream arbiter: merges S_COUNT inputs into one stream, never splitting a frame.
// Define AXIS_ARB_ROUND_ROBIN_EN for round-robin arbitration; default build is fixed priority (lowest index wins).
module axis_frame_arbiter #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = $clog2(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic                          grant_valid,
  output logic [ID_WIDTH-1:0]           grant_index
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0]            state_r;
  logic                  grant_valid_r;
  logic [ID_WIDTH-1:0]   grant_index_r;

  logic [S_COUNT-1:0]    search_s;
  logic [ID_WIDTH-1:0]   offset_s;
  logic                  found_s;
  logic [ID_WIDTH-1:0]   winner_s;
  logic                  any_req_s;

  logic [S_COUNT-1:0]    tready_s;
  logic [DATA_WIDTH-1:0] in_data_s;
  logic [USER_WIDTH-1:0] in_user_s;
  logic                  in_valid_s;
  logic                  in_last_s;
  logic                  in_ready_s;
  logic                  in_fire_s;
  logic                  sel_s;

  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [USER_WIDTH-1:0] out_user_r;
  logic                  out_last_r;
  logic [ID_WIDTH-1:0]   out_id_r;
  logic                  skid_valid_r;
  logic [DATA_WIDTH-1:0] skid_data_r;
  logic [USER_WIDTH-1:0] skid_user_r;
  logic                  skid_last_r;
  logic [ID_WIDTH-1:0]   skid_id_r;

  assign any_req_s = |s_axis_tvalid;

`ifdef AXIS_ARB_ROUND_ROBIN_EN
  logic [ID_WIDTH-1:0]  rr_ptr_r;
  logic [2*S_COUNT-1:0] req_dbl_s;
  logic [ID_WIDTH:0]    rr_sum_s;

  // Rotate requests so the search starts at the pointer, then map the offset back to a port index.
  assign req_dbl_s = {s_axis_tvalid, s_axis_tvalid} >> rr_ptr_r;
  assign search_s  = req_dbl_s[S_COUNT-1:0];
  assign rr_sum_s  = {1'b0, rr_ptr_r} + {1'b0, offset_s};
  assign winner_s  = (rr_sum_s >= (ID_WIDTH+1)'(S_COUNT)) ?
                     ID_WIDTH'(rr_sum_s - (ID_WIDTH+1)'(S_COUNT)) : rr_sum_s[ID_WIDTH-1:0];

  // Pointer sits one past the most recent grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= '0;
    end else if (state_r == IDLE && any_req_s) begin
      rr_ptr_r <= (winner_s == ID_WIDTH'(S_COUNT - 1)) ? '0 : winner_s + ID_WIDTH'(1);
    end
  end
`else
  assign search_s = s_axis_tvalid;
  assign winner_s = offset_s;
`endif

  // Lowest set bit of the search vector.
  always_comb begin
    offset_s = '0;
    found_s  = 1'b0;
    for (int j = 0; j < S_COUNT; j++) begin
      offset_s = offset_s | (ID_WIDTH'(j) & {ID_WIDTH{search_s[j] & ~found_s}});
      found_s  = found_s | search_s[j];
    end
  end

  assign in_ready_s = (state_r == ACTIVE) & ~skid_valid_r;

  // Mux the granted port and steer ready to it alone.
  always_comb begin
    in_data_s  = '0;
    in_user_s  = '0;
    in_valid_s = 1'b0;
    in_last_s  = 1'b0;
    tready_s   = '0;
    sel_s      = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      sel_s       = (grant_index_r == ID_WIDTH'(i));
      in_data_s   = in_data_s | (s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_s}});
      in_user_s   = in_user_s | (s_axis_tuser[i*USER_WIDTH +: USER_WIDTH] & {USER_WIDTH{sel_s}});
      in_valid_s  = in_valid_s | (s_axis_tvalid[i] & sel_s);
      in_last_s   = in_last_s | (s_axis_tlast[i] & sel_s);
      tready_s[i] = sel_s & in_ready_s;
    end
  end

  assign in_fire_s = in_ready_s & in_valid_s;

  // Grant is taken in IDLE and released only by an accepted tlast beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      grant_valid_r <= 1'b0;
      grant_index_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            state_r       <= ACTIVE;
            grant_valid_r <= 1'b1;
            grant_index_r <= winner_s;
          end
        end
        ACTIVE: begin
          if (in_fire_s && in_last_s) begin
            state_r       <= IDLE;
            grant_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r       <= IDLE;
          grant_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Output register with one skid entry; the skid catches the beat accepted while the output stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_user_r   <= '0;
      out_last_r   <= 1'b0;
      out_id_r     <= '0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= '0;
      skid_user_r  <= '0;
      skid_last_r  <= 1'b0;
      skid_id_r    <= '0;
    end else if (!out_valid_r || m_axis_tready) begin
      if (skid_valid_r) begin
        out_valid_r  <= 1'b1;
        out_data_r   <= skid_data_r;
        out_user_r   <= skid_user_r;
        out_last_r   <= skid_last_r;
        out_id_r     <= skid_id_r;
        skid_valid_r <= 1'b0;
      end else begin
        out_valid_r <= in_fire_s;
        if (in_fire_s) begin
          out_data_r <= in_data_s;
          out_user_r <= in_user_s;
          out_last_r <= in_last_s;
          out_id_r   <= grant_index_r;
        end
      end
    end else if (in_fire_s) begin
      skid_valid_r <= 1'b1;
      skid_data_r  <= in_data_s;
      skid_user_r  <= in_user_s;
      skid_last_r  <= in_last_s;
      skid_id_r    <= grant_index_r;
    end
  end

  assign s_axis_tready = tready_s;
  assign m_axis_tvalid = out_valid_r;
  assign m_axis_tdata  = out_data_r;
  assign m_axis_tuser  = out_user_r;
  assign m_axis_tlast  = out_last_r;
  assign m_axis_tid    = out_id_r;
  assign grant_valid   = grant_valid_r;
  assign grant_index   = grant_index_r;

endmodule
